if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage ARM pipeline. Holds the PC and drives it to the

---
 rtl/arm_pkg.sv | 22 ++
 rtl/if_id_reg.sv | 46 ++++
 rtl/if_stage.sv | 71 +++++++
 tb/tb_if_stage.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared constants and types for the ARM pipeline stages.
// IF uses them today; ID/EX import the same word width and reset defaults.
package arm_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] PC_STEP       = 32'd4;
  localparam logic [WORD_W-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
    logic              valid;
  } if_id_t;

  // Branch targets are word addresses; the two byte-offset bits are dropped.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, hold freezes every field.
// Flush takes priority over hold so a redirect is never lost to a stall.
module if_id_reg
  import arm_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic [WORD_W-1:0] pc_in,
  input  logic [WORD_W-1:0] instr_in,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] instr_out,
  output logic              valid_out
);

  localparam if_id_t BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

  if_id_t if_id_d;
  if_id_t if_id_q;

  // instr_in is only looked at on a real load, so X from memory never leaks in.
  always_comb begin
    if_id_d = if_id_q;
    if (flush) begin
      if_id_d = BUBBLE;
    end else if (!hold) begin
      if_id_d = '{pc: pc_in, instr: instr_in, valid: 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_q <= BUBBLE;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign pc_out    = if_id_q.pc;
  assign instr_out = if_id_q.instr;
  assign valid_out = if_id_q.valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and
// a count of instructions committed into IF/ID.
module if_stage
  import arm_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_addr,
  input  logic [WORD_W-1:0] instr_in,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] if_id_pc,
  output logic [WORD_W-1:0] if_id_instr,
  output logic              if_id_valid,
  output logic [WORD_W-1:0] fetch_count
);

  logic [WORD_W-1:0] pc_d, pc_q;
  logic [WORD_W-1:0] fetch_count_d, fetch_count_q;
  logic [WORD_W-1:0] pc_plus4;
  logic              load;

  // One adder feeds both the sequential next PC and the PC+4 handed to decode.
  assign pc_plus4 = pc_q + PC_STEP;
  assign load     = !branch_taken && !freeze;

  always_comb begin
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    if (branch_taken) begin
      pc_d = word_align(branch_addr);
    end else if (!freeze) begin
      pc_d = pc_plus4;
    end
    if (load) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (branch_taken),
    .hold     (freeze),
    .pc_in    (pc_plus4),
    .instr_in (instr_in),
    .pc_out   (if_id_pc),
    .instr_out(if_id_instr),
    .valid_out(if_id_valid)
  );

  assign pc_out      = pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, freeze, branch flush,
// branch-with-freeze, unaligned target and PC wrap.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;
  localparam logic [31:0] KEY = 32'hE59F_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory stand-in: the word at address p is p ^ KEY.
  assign instr_in = pc_out ^ KEY;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .instr_in    (instr_in),
    .pc_out      (pc_out),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .fetch_count (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                         input logic [31:0] instr, input logic vld, input logic [31:0] cnt);
    chk({tag, ".pc_out"},      pc_out,      pc);
    chk({tag, ".if_id_pc"},    if_id_pc,    ipc);
    chk({tag, ".if_id_instr"}, if_id_instr, instr);
    chk({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, vld});
    chk({tag, ".fetch_count"}, fetch_count, cnt);
  endtask

  initial begin
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;

    // Reset asserted between edges must act immediately.
    #2 rst = 1'b1;
    #1;
    chk_all("reset_async", 32'h0, 32'h0, NOP, 1'b0, 32'd0);
    edge_step();
    edge_step();
    chk_all("reset_held", 32'h0, 32'h0, NOP, 1'b0, 32'd0);
    rst = 1'b0;

    // Sequential fetch: after edge i, PC = 4i and IF/ID holds the word from 4(i-1).
    for (int i = 1; i <= 4; i++) begin
      edge_step();
      chk_all($sformatf("seq%0d", i), 32'(4 * i), 32'(4 * i),
              32'(4 * (i - 1)) ^ KEY, 1'b1, 32'(i));
    end

    // Freeze for three edges at PC 16: nothing moves.
    freeze = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      edge_step();
      chk_all($sformatf("frz%0d", i), 32'd16, 32'd16, 32'd12 ^ KEY, 1'b1, 32'd4);
    end
    freeze = 1'b0;
    edge_step();
    chk_all("frz_rel", 32'd20, 32'd20, 32'd16 ^ KEY, 1'b1, 32'd5);

    // Taken branch from PC 20 to 0x40: bubble enters IF/ID.
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    edge_step();
    chk_all("br", 32'h40, 32'h0, NOP, 1'b0, 32'd5);
    branch_taken = 1'b0;
    edge_step();
    chk_all("br_tgt", 32'h44, 32'h44, 32'h40 ^ KEY, 1'b1, 32'd6);

    // Branch and freeze together, unaligned target: branch wins, low bits dropped.
    freeze       = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h103;
    edge_step();
    chk_all("brfrz", 32'h100, 32'h0, NOP, 1'b0, 32'd6);
    branch_taken = 1'b0;
    edge_step();
    chk_all("brfrz_hold", 32'h100, 32'h0, NOP, 1'b0, 32'd6);
    freeze = 1'b0;
    edge_step();
    chk_all("brfrz_rel", 32'h104, 32'h104, 32'h100 ^ KEY, 1'b1, 32'd7);

    // Last word of the address space: PC and PC+4 both wrap to zero.
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFE;
    edge_step();
    chk_all("wrap_br", 32'hFFFF_FFFC, 32'h0, NOP, 1'b0, 32'd7);
    branch_taken = 1'b0;
    edge_step();
    chk_all("wrap", 32'h0, 32'h0, 32'hFFFF_FFFC ^ KEY, 1'b1, 32'd8);

    // Mid-run asynchronous reset.
    edge_step();
    #3 rst = 1'b1;
    #1;
    chk_all("reset_mid", 32'h0, 32'h0, NOP, 1'b0, 32'd0);
    edge_step();
    rst = 1'b0;
    edge_step();
    chk_all("post_reset", 32'd4, 32'd4, 32'd0 ^ KEY, 1'b1, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
